crossbar_slave_arbiter: RTL and testbench

// - Per-slave-port arbiter and sequencer for the crossbar: picks one of N_MASTERS requesting masters

---
 rtl/crossbar_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/crossbar_slave_arbiter.sv | 125 ++++++++++++
 tb/tb_crossbar_slave_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar slave-port arbiters: default sizing,
// arbiter FSM states and command encodings.
package crossbar_pkg;

    localparam int N_MASTERS_DEF = 4;
    localparam int DATA_W_DEF    = 32;
    localparam int TIMEOUT_DEF   = 255;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer,
// wrapping from the highest index back to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = 0;
        for (int k = 0; k < N; k++) begin
            w_cand = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[w_cand]) begin
                o_valid         = 1'b1;
                o_idx           = IDX_W'(w_cand);
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossbar_slave_arbiter.sv
// Per-slave-port arbiter: grants one master round-robin, muxes its request to
// the slave and steers the slave's completion back to that master only.
module crossbar_slave_arbiter
    import crossbar_pkg::*;
#(
    parameter int N_MASTERS = N_MASTERS_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_MASTERS-1:0]      req_from_masters,
    input  logic [N_MASTERS*DATA_W-1:0] addr_from_masters,
    input  logic [N_MASTERS*DATA_W-1:0] wdata_from_masters,
    input  logic [N_MASTERS-1:0]      cmd_from_masters,
    input  logic                      ack_from_slave,
    input  logic [DATA_W-1:0]         rdata_from_slave,
    output logic [N_MASTERS-1:0]      connect_approved,
    output logic                      req_to_slave,
    output logic [DATA_W-1:0]         addr_to_slave,
    output logic [DATA_W-1:0]         wdata_to_slave,
    output logic                      cmd_to_slave,
    output logic [N_MASTERS-1:0]      ack_to_masters,
    output logic [DATA_W-1:0]         rdata_to_slave_owner,
    output logic                      timeout_err
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    state_e                 r_state;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_ptr;
    logic [7:0]             r_cnt;
    logic [N_MASTERS-1:0]   r_grant;
    logic                   r_timeout_err;

    logic [N_MASTERS-1:0]   w_arb_grant;
    logic [IDX_W-1:0]       w_arb_idx;
    logic                   w_arb_valid;
    logic                   w_granted;
    logic                   w_owner_req;
    logic                   w_expired;
    logic                   w_done;

    rr_arbiter #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req   (req_from_masters),
        .i_ptr   (r_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_valid (w_arb_valid)
    );

    assign w_granted   = (r_state == GRANT);
    assign w_owner_req = req_from_masters[r_owner];
    assign w_done      = w_granted && ack_from_slave;
    // Expiry is the cycle in which the wait count would reach TIMEOUT.
    assign w_expired   = (r_cnt >= 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_owner       <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_grant       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_state <= GRANT;
                        r_owner <= w_arb_idx;
                        r_grant <= w_arb_grant;
                        r_cnt   <= '0;
                        r_ptr   <= (w_arb_idx == IDX_W'(N_MASTERS - 1)) ?
                                   '0 : w_arb_idx + IDX_W'(1);
                    end
                end
                GRANT: begin
                    // Ack outranks both abort and expiry in the same cycle.
                    if (ack_from_slave || !w_owner_req) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                    end else if (w_expired) begin
                        r_state       <= IDLE;
                        r_grant       <= '0;
                        r_timeout_err <= 1'b1;
                    end else if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    always_comb begin
        req_to_slave         = w_granted && w_owner_req;
        addr_to_slave        = '0;
        wdata_to_slave       = '0;
        cmd_to_slave         = CMD_READ;
        ack_to_masters       = '0;
        rdata_to_slave_owner = '0;
        if (w_granted) begin
            addr_to_slave  = addr_from_masters[int'(r_owner)*DATA_W +: DATA_W];
            wdata_to_slave = wdata_from_masters[int'(r_owner)*DATA_W +: DATA_W];
            cmd_to_slave   = cmd_from_masters[r_owner];
        end
        if (w_done) begin
            ack_to_masters       = r_grant;
            rdata_to_slave_owner = rdata_from_slave;
        end
    end

    assign connect_approved = r_grant;
    assign timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// Self-checking bench for crossbar_slave_arbiter: directed scenarios with literal
// expectations plus a long randomized run against a behavioural model.
module tb_crossbar_slave_arbiter;

    localparam int NM = 4;
    localparam int DW = 32;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NM-1:0]     reqVec = '0;
    logic [NM*DW-1:0]  addrBus = '0;
    logic [NM*DW-1:0]  wdataBus = '0;
    logic [NM-1:0]     cmdVec = '0;
    logic              ackIn = 1'b0;
    logic [DW-1:0]     rdataIn = '0;

    logic [NM-1:0]     connect_approved;
    logic              req_to_slave;
    logic [DW-1:0]     addr_to_slave;
    logic [DW-1:0]     wdata_to_slave;
    logic              cmd_to_slave;
    logic [NM-1:0]     ack_to_masters;
    logic [DW-1:0]     rdata_to_slave_owner;
    logic              timeout_err;

    int totalCount = 0;
    int badCount   = 0;
    bit checkEn    = 1'b0;

    bit mBusy  = 1'b0;
    int mOwner = 0;
    int mPtr   = 0;
    int mWait  = 0;
    bit mErr   = 1'b0;
    int mIdx;
    bit mFound;

    always #5 clk = ~clk;

    crossbar_slave_arbiter #(
        .N_MASTERS (NM),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .req_from_masters     (reqVec),
        .addr_from_masters    (addrBus),
        .wdata_from_masters   (wdataBus),
        .cmd_from_masters     (cmdVec),
        .ack_from_slave       (ackIn),
        .rdata_from_slave     (rdataIn),
        .connect_approved     (connect_approved),
        .req_to_slave         (req_to_slave),
        .addr_to_slave        (addr_to_slave),
        .wdata_to_slave       (wdata_to_slave),
        .cmd_to_slave         (cmd_to_slave),
        .ack_to_masters       (ack_to_masters),
        .rdata_to_slave_owner (rdata_to_slave_owner),
        .timeout_err          (timeout_err)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [NM-1:0] r, input logic a);
        @(negedge clk);
        reqVec  = r;
        ackIn   = a;
        rdataIn = $urandom;
    endtask

    // Model: one owner at a time, a counted wait with forced release, and a
    // fair pointer that moves past each winner.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mBusy = 1'b0; mOwner = 0; mPtr = 0; mWait = 0; mErr = 1'b0;
        end else if (!mBusy) begin
            mErr = 1'b0;
            mFound = 1'b0;
            for (int k = 0; k < NM; k++) begin
                mIdx = (mPtr + k) % NM;
                if (!mFound && reqVec[mIdx]) begin
                    mFound = 1'b1;
                    mOwner = mIdx;
                end
            end
            if (mFound) begin
                mBusy = 1'b1;
                mWait = 0;
                mPtr  = (mOwner + 1) % NM;
            end
        end else if (ackIn || !reqVec[mOwner]) begin
            mBusy = 1'b0;
            mErr  = 1'b0;
        end else begin
            mWait++;
            mErr = 1'b0;
            if (mWait >= TO) begin
                mBusy = 1'b0;
                mErr  = 1'b1;
            end
        end
    end

    task automatic checkModel();
        logic [NM-1:0] eGrant;
        logic          done;
        eGrant = mBusy ? NM'(1 << mOwner) : '0;
        done   = mBusy && ackIn;
        checkOutput("mdlGrant", connect_approved, eGrant);
        checkOutput("mdlReqToSlave", req_to_slave, mBusy && reqVec[mOwner]);
        checkOutput("mdlAddr", addr_to_slave, mBusy ? addrBus[mOwner*DW +: DW] : '0);
        checkOutput("mdlWdata", wdata_to_slave, mBusy ? wdataBus[mOwner*DW +: DW] : '0);
        checkOutput("mdlCmd", cmd_to_slave, mBusy && cmdVec[mOwner]);
        checkOutput("mdlAck", ack_to_masters, done ? eGrant : '0);
        checkOutput("mdlRdata", rdata_to_slave_owner, done ? rdataIn : '0);
        checkOutput("mdlTimeoutErr", timeout_err, mErr);
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            #2;
            checkModel();
        end
    end

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        reqVec = '0;
        ackIn  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NM-1:0] rrSeen [5];
        logic [NM-1:0] rrWant [5];
        logic [NM-1:0] nextReq;
        int pulses;

        rrWant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        checkEn = 1'b1;

        reqVec = 4'b1111;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("rstGrant", connect_approved, 4'b0000);
        checkOutput("rstReqToSlave", req_to_slave, 1'b0);
        checkOutput("rstAddr", addr_to_slave, 32'h0);
        checkOutput("rstTimeoutErr", timeout_err, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        reqVec = '0;

        addrBus[2*DW +: DW]  = 32'h1000_0040;
        wdataBus[2*DW +: DW] = 32'hCAFE_0002;
        cmdVec[2]            = 1'b1;
        applyStimulus(4'b0100, 1'b0); #3;
        checkOutput("smPreGrant", connect_approved, 4'b0000);
        applyStimulus(4'b0100, 1'b0); #3;
        checkOutput("smGrant", connect_approved, 4'b0100);
        checkOutput("smAddr", addr_to_slave, 32'h1000_0040);
        checkOutput("smCmd", cmd_to_slave, 1'b1);
        applyStimulus(4'b0100, 1'b1); #3;
        checkOutput("smAck", ack_to_masters, 4'b0100);
        applyStimulus(4'b0000, 1'b0); #3;
        checkOutput("smRelease", connect_approved, 4'b0000);

        applyStimulus(4'b1001, 1'b0); #3;
        checkOutput("frIdle", connect_approved, 4'b0000);
        applyStimulus(4'b1001, 1'b0); #3;
        checkOutput("frFirst", connect_approved, 4'b1000);
        applyStimulus(4'b1001, 1'b1);
        applyStimulus(4'b0001, 1'b0); #3;
        checkOutput("frBubble", connect_approved, 4'b0000);
        applyStimulus(4'b0001, 1'b0); #3;
        checkOutput("frSecond", connect_approved, 4'b0001);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0000, 1'b0);

        doReset();
        for (int g = 0; g < 5; g++) begin
            applyStimulus(4'b1111, 1'b0); #3;
            checkOutput("rrBubble", connect_approved, 4'b0000);
            applyStimulus(4'b1111, 1'b0); #3;
            rrSeen[g] = connect_approved;
            applyStimulus(4'b1111, 1'b1);
        end
        for (int g = 0; g < 5; g++) checkOutput("rrOrder", rrSeen[g], rrWant[g]);
        applyStimulus(4'b0000, 1'b0);

        pulses = 0;
        for (int c = 1; c <= 9; c++) begin
            applyStimulus(4'b0010, 1'b0); #3;
            if (timeout_err) pulses++;
            if (c == 6) begin
                checkOutput("toGrantDropped", connect_approved, 4'b0000);
                checkOutput("toErrCycle", timeout_err, 1'b1);
            end
            if (c == 7) checkOutput("toRegrant", connect_approved, 4'b0010);
        end
        checkOutput("toPulses", pulses, 1);

        applyStimulus(4'b0000, 1'b0); #3;
        checkOutput("abReqGone", req_to_slave, 1'b0);
        applyStimulus(4'b0000, 1'b0); #3;
        checkOutput("abIdle", connect_approved, 4'b0000);

        applyStimulus(4'b0010, 1'b0);
        repeat (3) applyStimulus(4'b0010, 1'b0);
        applyStimulus(4'b0010, 1'b1); #3;
        checkOutput("exAck", ack_to_masters, 4'b0010);
        applyStimulus(4'b0000, 1'b0); #3;
        checkOutput("exNoErr", timeout_err, 1'b0);
        checkOutput("exGrant", connect_approved, 4'b0000);

        applyStimulus(4'b0000, 1'b1); #3;
        checkOutput("spAck", ack_to_masters, 4'b0000);
        checkOutput("spRdata", rdata_to_slave_owner, 32'h0);

        applyStimulus(4'b0100, 1'b0);
        applyStimulus(4'b0100, 1'b0); #3;
        checkOutput("arGranted", connect_approved, 4'b0100);
        ackIn = 1'b1;
        rst_n = 1'b0;
        #1;
        checkOutput("arGrantDrop", connect_approved, 4'b0000);
        checkOutput("arNoAck", ack_to_masters, 4'b0000);
        @(negedge clk);
        rst_n  = 1'b1;
        ackIn  = 1'b0;
        reqVec = '0;

        for (int n = 0; n < 3000; n++) begin
            nextReq = reqVec;
            for (int i = 0; i < NM; i++) begin
                if (nextReq[i]) begin
                    if ($urandom_range(15) == 0) nextReq[i] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    nextReq[i] = 1'b1;
                end
            end
            addrBus  = {$urandom, $urandom, $urandom, $urandom};
            wdataBus = {$urandom, $urandom, $urandom, $urandom};
            cmdVec   = NM'($urandom);
            applyStimulus(nextReq, ($urandom_range(3) == 0));
        end

        @(negedge clk);
        checkEn = 1'b0;
        #5;
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
